c3po_port_arbiter: RTL and testbench
====================================

Name: c3po_port_arbiter

Overview:
- Packet-level round-robin arbiter sharing the single c3po output channel among PORTS_P input ports.
- Grants one enabled, requesting port at a time and holds the grant from first beat through the EOP beat.
- Watches the granted packet for a runaway length and counts completed packets.
- Sits between the per-port input queues and the output datapath mux; its grant drives per-port ready and the mux select.

Parameters:
PORTS_P, 4, number of requesting input ports (2..16)
MAX_BEATS_P, 64, max accepted beats per packet before timeout abort
CNT_SIZE_P, 8, width of completed-packet counter
ID_W_P, $clog2(PORTS_P), width of grant index

Ports:
sig_clock  in  1  clock, all state on rising edge
sig_reset_L  in  1  reset, asynchronous, active-low
sig_req  in  PORTS_P  port i holds a packet ready to send
sig_ctrl_port_enable  in  PORTS_P  port i eligible for arbitration
sig_val  in  1  valid beat on muxed datapath (granted port)
sig_eop  in  1  end of packet on muxed datapath, qualified by sig_val
sig_out_ready  in  1  downstream accepts beat this cycle
sig_grant  out  PORTS_P  one-hot grant; acts as per-port ready
sig_grant_id  out  ID_W_P  binary index of granted port (mux select)
sig_busy  out  1  grant active
sig_err  out  1  one-cycle pulse on timeout abort
sig_pkt_cnt  out  CNT_SIZE_P  completed packets, saturating

Behaviour:
- Clock/reset: one clock, sig_clock; reset sig_reset_L, asynchronous, active-low.
- Reset values: sig_grant=0, sig_grant_id=0, sig_busy=0, sig_err=0, sig_pkt_cnt=0, state=IDLE, beat counter=0, last_ptr=PORTS_P-1 (port 0 has top priority after reset).
- All outputs are registered.
- A beat is accepted when sig_busy && sig_val && sig_out_ready. sig_val while not busy is ignored.
- FSM has 2 states.
- IDLE:
  - eligible = sig_req & sig_ctrl_port_enable.
  - If eligible!=0: pick the first set index scanning last_ptr+1, last_ptr+2, ... with wrap modulo PORTS_P.
  - Next edge: sig_grant one-hot at winner, sig_grant_id=winner, sig_busy=1, last_ptr=winner, beat counter=0, state=BUSY.
  - Latency: request sampled at edge N gives grant visible after edge N; no combinational req->grant path.
- BUSY:
  - Grant held constant. The beat counter increments per accepted beat; it is not incremented on the EOP beat.
  - Accepted beat with sig_eop=1:
    - Next edge: grant=0, busy=0, state=IDLE.
    - sig_pkt_cnt+1, holding at all-ones.
    - A mandatory one-cycle bubble follows before the next grant.
  - Timeout: the beat counter reaches MAX_BEATS_P with no EOP on that beat.
    - Next edge: grant=0, busy=0, sig_err=1 for exactly one cycle, state=IDLE.
    - sig_pkt_cnt unchanged; last_ptr keeps the aborted port, so it has lowest priority next round.
- Boundaries:
  - sig_out_ready=0: no beat is counted and no EOP is recognised; the grant is held indefinitely (no stall timeout).
  - Enable or req dropped by the granted port mid-packet: grant is NOT revoked; the packet runs to EOP or timeout.
  - A single-beat packet (first beat has EOP) is legal: busy for exactly 1 accept cycle.
  - Only one eligible port: it wins every round with the one-cycle bubble between packets.
  - Reset mid-packet: immediate return to reset values; no sig_err pulse.
  - sig_eop without sig_val is ignored.

Test Plan:
- Reset, then sig_req=4'b1111 with all enabled and 1-beat packets, ready=1 -> grant order 0,1,2,3,0; grant asserted every other cycle; sig_pkt_cnt=5.
- sig_req=4'b1010 and enable=4'b1000, 3-beat packet -> only port 3 is granted; grant_id=3 held 3 accept cycles; drops the cycle after the EOP beat.
- Port 1 granted; sig_out_ready toggled 1,0,0,1,1 with EOP on the last accepted beat -> grant held through the stalls; released after the 3rd accepted beat; pkt_cnt+1.
- MAX_BEATS_P=4, port 2 streams without EOP, req=4'b0110 -> sig_err pulses 1 cycle after the 4th beat; next grant goes to port 1 (wrap past 3,0); pkt_cnt unchanged.
- CNT_SIZE_P=2, send 5 packets -> sig_pkt_cnt reads 1,2,3,3,3.
- Assert sig_reset_L=0 mid-packet on port 2 -> grant=0 and busy=0 asynchronously; after release with req=4'b1111 the first grant goes to port 0.

Source files
------------

// File: rtl/c3po_port_arbiter.sv
// c3po_port_arbiter: packet-level round-robin arbiter for the shared c3po
// output channel. It grants one enabled, requesting port at a time and holds
// that grant from the first beat through the EOP beat. It aborts a packet that
// runs past MAX_BEATS_P beats, and it counts completed packets in a saturating
// counter.
//
// Ports:
//   sig_clock            clock; all state updates on the rising edge
//   sig_reset_L          asynchronous active-low reset
//   sig_req              per-port packet-ready request
//   sig_ctrl_port_enable per-port arbitration eligibility
//   sig_val              valid beat on the muxed datapath (from the granted port)
//   sig_eop              end of packet, qualified by sig_val
//   sig_out_ready        downstream accepts a beat this cycle
//   sig_grant            one-hot grant; used as the per-port ready
//   sig_grant_id         binary index of the granted port; drives the mux select
//   sig_busy             a grant is active
//   sig_err              one-cycle pulse on a timeout abort
//   sig_pkt_cnt          saturating count of completed packets
module c3po_port_arbiter #(
    parameter int unsigned PORTS_P     = 4,
    parameter int unsigned MAX_BEATS_P = 64,
    parameter int unsigned CNT_SIZE_P  = 8,
    parameter int unsigned ID_W_P      = $clog2(PORTS_P)
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset_L,
    input  logic [PORTS_P-1:0]    sig_req,
    input  logic [PORTS_P-1:0]    sig_ctrl_port_enable,
    input  logic                  sig_val,
    input  logic                  sig_eop,
    input  logic                  sig_out_ready,
    output logic [PORTS_P-1:0]    sig_grant,
    output logic [ID_W_P-1:0]     sig_grant_id,
    output logic                  sig_busy,
    output logic                  sig_err,
    output logic [CNT_SIZE_P-1:0] sig_pkt_cnt
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS_P + 1);
    localparam int unsigned SUM_W  = ID_W_P + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PORTS_P-1:0]      grant_q, grant_d;
    logic [ID_W_P-1:0]       grant_id_q, grant_id_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [CNT_SIZE_P-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ID_W_P-1:0]       last_ptr_q, last_ptr_d;

    logic [PORTS_P-1:0]      eligible;
    logic                    found;
    logic [ID_W_P-1:0]       winner;
    logic [SUM_W-1:0]        scan_idx;
    logic                    accept;

    // Round-robin search starting just after the last granted port, with wrap
    always_comb begin
        eligible = sig_req & sig_ctrl_port_enable;
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 1; i <= int'(PORTS_P); i++) begin
            scan_idx = SUM_W'(last_ptr_q) + SUM_W'(i);
            if (scan_idx >= SUM_W'(PORTS_P)) begin
                scan_idx = scan_idx - SUM_W'(PORTS_P);
            end
            if (!found && eligible[scan_idx[ID_W_P-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[ID_W_P-1:0];
            end
        end
    end

    assign accept = busy_q && sig_val && sig_out_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        beat_d     = beat_q;
        last_ptr_d = last_ptr_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    busy_d          = 1'b1;
                    last_ptr_d      = winner;
                    beat_d          = '0;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    if (sig_eop) begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        if (pkt_cnt_q != {CNT_SIZE_P{1'b1}}) begin
                            pkt_cnt_d = pkt_cnt_q + CNT_SIZE_P'(1);
                        end
                    end else if (beat_q == BEAT_W'(MAX_BEATS_P - 1)) begin
                        // This beat would reach the limit without EOP: abort
                        grant_d = '0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            beat_q     <= '0;
            last_ptr_q <= ID_W_P'(PORTS_P - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            beat_q     <= beat_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign sig_grant    = grant_q;
    assign sig_grant_id = grant_id_q;
    assign sig_busy     = busy_q;
    assign sig_err      = err_q;
    assign sig_pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_c3po_port_arbiter.sv
// Directed bench for c3po_port_arbiter. The main instance uses a short timeout
// (4 beats). The second instance, with a 2-bit packet counter, shares all
// stimulus and shows the counter saturating.
module tb_c3po_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic       val;
    logic       eop;
    logic       rdy;

    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       err;
    logic [7:0] pkt_cnt;

    logic [3:0] s_grant;
    logic [1:0] s_grant_id;
    logic       s_busy;
    logic       s_err;
    logic [1:0] s_pkt_cnt;

    int checks   = 0;
    int failures = 0;

    c3po_port_arbiter #(
        .PORTS_P(4), .MAX_BEATS_P(4), .CNT_SIZE_P(8), .ID_W_P(2)
    ) dut (
        .sig_clock(clk), .sig_reset_L(rst_n),
        .sig_req(req), .sig_ctrl_port_enable(en),
        .sig_val(val), .sig_eop(eop), .sig_out_ready(rdy),
        .sig_grant(grant), .sig_grant_id(grant_id), .sig_busy(busy),
        .sig_err(err), .sig_pkt_cnt(pkt_cnt)
    );

    c3po_port_arbiter #(
        .PORTS_P(4), .MAX_BEATS_P(4), .CNT_SIZE_P(2), .ID_W_P(2)
    ) dut_s (
        .sig_clock(clk), .sig_reset_L(rst_n),
        .sig_req(req), .sig_ctrl_port_enable(en),
        .sig_val(val), .sig_eop(eop), .sig_out_ready(rdy),
        .sig_grant(s_grant), .sig_grant_id(s_grant_id), .sig_busy(s_busy),
        .sig_err(s_err), .sig_pkt_cnt(s_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [7:0] exp_cnt);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
    endtask

    task automatic check_grant(input string tag, input int port);
        check({tag, "_grant"}, 32'(grant), 32'(1) << port);
        check({tag, "_id"}, 32'(grant_id), 32'(port));
        check({tag, "_busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        en    = 4'b0000;
        val   = 1'b0;
        eop   = 1'b0;
        rdy   = 1'b0;

        // Reset values
        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", 32'(pkt_cnt), 32'h0);
        check("rst_s_cnt", 32'(s_pkt_cnt), 32'h0);
        tick;
        rst_n = 1'b1;
        tick;

        // All ports requesting, 1-beat packets: round robin 0,1,2,3,0 with a bubble between grants
        req = 4'b1111; en = 4'b1111; val = 1'b1; eop = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            check_grant("rr", k % 4);
            check("rr_s_grant", 32'(s_grant), 32'(1) << (k % 4));
            check("rr_s_id", 32'(s_grant_id), 32'(k % 4));
            check("rr_s_busy", 32'(s_busy), 32'h1);
            tick;
            check_idle("rr_rel", 8'(k + 1));
            check("rr_s_cnt", 32'(s_pkt_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            check("rr_s_err", 32'(s_err), 32'h0);
        end

        // Only port 3 is eligible; 3-beat packet
        req = 4'b1010; en = 4'b1000; eop = 1'b0;
        tick;
        check_grant("p3", 3);
        tick;
        check_grant("p3_b1", 3);
        tick;
        check_grant("p3_b2", 3);
        eop = 1'b1;
        tick;
        check_idle("p3_rel", 8'd6);
        check("p3_err", 32'(err), 32'h0);

        // Port 1 with downstream stalls; dropping req/en mid-packet does not revoke the grant
        req = 4'b0010; en = 4'b1111; eop = 1'b0; rdy = 1'b1;
        tick;
        check_grant("st", 1);
        tick;                                   // beat 1 accepted
        check_grant("st_b1", 1);
        rdy = 1'b0; eop = 1'b1; req = 4'b0000; en = 4'b0000;
        tick;                                   // stall: EOP not recognised
        check_grant("st_s1", 1);
        tick;
        check_grant("st_s2", 1);
        rdy = 1'b1; eop = 1'b0;
        tick;                                   // beat 2 accepted
        check_grant("st_b2", 1);
        eop = 1'b1;
        tick;                                   // beat 3 with EOP
        check_idle("st_rel", 8'd7);

        // Timeout: port 2 streams 4 beats without EOP
        req = 4'b0110; en = 4'b1111; eop = 1'b0;
        tick;
        check_grant("to", 2);
        for (int b = 1; b <= 3; b++) begin
            tick;
            check_grant("to_beat", 2);
            check("to_err_lo", 32'(err), 32'h0);
        end
        tick;
        check_idle("to_abort", 8'd7);
        check("to_err_pulse", 32'(err), 32'h1);
        tick;
        check("to_err_clr", 32'(err), 32'h0);
        check_grant("to_next", 1);              // wrap past 3 and 0 to port 1

        // EOP without valid is ignored
        val = 1'b0; eop = 1'b1;
        tick;
        check_grant("nv1", 1);
        tick;
        check_grant("nv2", 1);
        val = 1'b1;
        tick;
        check_idle("nv_rel", 8'd8);
        check("nv_s_cnt", 32'(s_pkt_cnt), 32'd3);

        // Asynchronous reset in the middle of a packet on port 2
        req = 4'b0100; eop = 1'b0;
        tick;
        check_grant("ar", 2);
        tick;
        check_grant("ar_b1", 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_err", 32'(err), 32'h0);
        check("ar_cnt", 32'(pkt_cnt), 32'h0);
        check("ar_s_cnt", 32'(s_pkt_cnt), 32'h0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check_grant("ar_first", 0);
        check("ar_err2", 32'(err), 32'h0);
        eop = 1'b1;
        tick;
        check_idle("ar_rel", 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
